// File: rtl/seg_scan_display_if.sv
// Bus bundle for seg_scan_display: control, capture data and the LED drive outputs.
// Optional blink input is present only when SEG_BLINK_EN is defined.
interface seg_scan_display_if #(
  parameter int unsigned N_DIGITS = 8
);
  logic                  button;
  logic                  locked;
  logic                  load;
  logic [4*N_DIGITS-1:0] data;
  logic [N_DIGITS-1:0]   dp_mask;
  logic                  lz_blank;
`ifdef SEG_BLINK_EN
  logic                  blink;
`endif
  logic [N_DIGITS-1:0]   led_en;
  logic [7:0]            led_w;

`ifdef SEG_BLINK_EN
  modport master (
    output button, locked, load, data, dp_mask, lz_blank, blink,
    input  led_en, led_w
  );
  modport slave (
    input  button, locked, load, data, dp_mask, lz_blank, blink,
    output led_en, led_w
  );
`else
  modport master (
    output button, locked, load, data, dp_mask, lz_blank,
    input  led_en, led_w
  );
  modport slave (
    input  button, locked, load, data, dp_mask, lz_blank,
    output led_en, led_w
  );
`endif
endinterface

// File: rtl/seg_scan_display.sv
// Multiplexed 7-segment scanner: holds each digit SCAN_CNT_MAX cycles, decodes the
// captured hex value with optional decimal point and leading-zero blanking.
// Optional feature macro: SEG_BLINK_EN (adds blink input and blink phase timer).
module seg_scan_display #(
  parameter int unsigned N_DIGITS      = 8,
  parameter int unsigned SCAN_CNT_MAX  = 200000,
  parameter int unsigned BLINK_CNT_MAX = 25000000
) (
  input logic               clk,
  input logic               rst,
  seg_scan_display_if.slave bus
);

  localparam int unsigned ScanW = (SCAN_CNT_MAX > 1) ? $clog2(SCAN_CNT_MAX) : 1;
  localparam int unsigned PosW  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  if (N_DIGITS < 1 || N_DIGITS > 8 || SCAN_CNT_MAX < 1 || BLINK_CNT_MAX < 1) begin : g_param_check
    $error("seg_scan_display: illegal parameter value");
  end

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e                state_q;
  logic [ScanW-1:0]      scan_cnt_q;
  logic [PosW-1:0]       scan_pos_q;
  logic [N_DIGITS-1:0]   led_en_q;
  logic [7:0]            led_w_q;
  logic [4*N_DIGITS-1:0] cap_data_q;
  logic [N_DIGITS-1:0]   cap_dp_q;

  logic [3:0] cur_digit;
  logic       cur_dp;
  logic       upper_zero;
  logic       cur_blank;
  logic       blink_off;
  logic [7:0] seg_pattern;

  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    logic [6:0] s;
    unique case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h18;
      4'ha: s = 7'h08;
      4'hb: s = 7'h03;
      4'hc: s = 7'h46;
      4'hd: s = 7'h21;
      4'he: s = 7'h06;
      4'hf: s = 7'h0e;
    endcase
    return s;
  endfunction

  // Select the current digit from the captured copy and decide leading-zero blanking.
  always_comb begin
    cur_digit  = 4'h0;
    cur_dp     = 1'b0;
    upper_zero = 1'b1;
    cur_blank  = 1'b0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      // upper_zero covers digit i and everything to its left
      upper_zero = upper_zero && (cap_data_q[4*i +: 4] == 4'h0);
      if (scan_pos_q == PosW'(i)) begin
        cur_digit = cap_data_q[4*i +: 4];
        cur_dp    = cap_dp_q[i];
        cur_blank = bus.lz_blank && (i != 0) && upper_zero;
      end
    end
    seg_pattern = (cur_blank || blink_off) ? 8'hff : {~cur_dp, seg_decode(cur_digit)};
  end

  // Capture register: display never reads live data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cap_data_q <= '0;
      cap_dp_q   <= '0;
    end else if (bus.load) begin
      cap_data_q <= bus.data;
      cap_dp_q   <= bus.dp_mask;
    end
  end

  // FSM, scan timer and registered outputs; enable and segments share one edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      scan_cnt_q <= '0;
      scan_pos_q <= '0;
      led_en_q   <= '1;
      led_w_q    <= 8'hff;
    end else if (bus.locked) begin
      state_q    <= StIdle;
      scan_cnt_q <= '0;
      scan_pos_q <= '0;
      led_en_q   <= '1;
      led_w_q    <= 8'hff;
    end else begin
      unique case (state_q)
        StIdle: begin
          scan_cnt_q <= '0;
          scan_pos_q <= '0;
          led_en_q   <= '1;
          led_w_q    <= 8'hff;
          if (bus.button) state_q <= StRun;
        end
        StRun: begin
          led_en_q <= ~(N_DIGITS'(1) << scan_pos_q);
          led_w_q  <= seg_pattern;
          if (scan_cnt_q == ScanW'(SCAN_CNT_MAX - 1)) begin
            scan_cnt_q <= '0;
            scan_pos_q <= (scan_pos_q == PosW'(N_DIGITS - 1)) ? '0 : scan_pos_q + 1'b1;
          end else begin
            scan_cnt_q <= scan_cnt_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef SEG_BLINK_EN
  localparam int unsigned BlinkW = (BLINK_CNT_MAX > 1) ? $clog2(BLINK_CNT_MAX) : 1;

  logic [BlinkW-1:0] blink_cnt_q;
  logic              blink_off_q;

  // Blink phase timer: runs only while blink is requested in RUN, otherwise phase is on.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt_q <= '0;
      blink_off_q <= 1'b0;
    end else if (state_q != StRun || bus.locked || !bus.blink) begin
      blink_cnt_q <= '0;
      blink_off_q <= 1'b0;
    end else if (blink_cnt_q == BlinkW'(BLINK_CNT_MAX - 1)) begin
      blink_cnt_q <= '0;
      blink_off_q <= ~blink_off_q;
    end else begin
      blink_cnt_q <= blink_cnt_q + 1'b1;
    end
  end

  assign blink_off = blink_off_q;
`else
  assign blink_off = 1'b0;
`endif

  assign bus.led_en = led_en_q;
  assign bus.led_w  = led_w_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// Self-checking bench for seg_scan_display: directed scenarios plus random traffic,
// compared every cycle against an arithmetic model of the display.
module tb_seg_scan_display;

  localparam int unsigned N    = 8;
  localparam int unsigned SCAN = 5;

  logic clk = 1'b0;
  logic rst;

  seg_scan_display_if #(.N_DIGITS(N)) bus ();

  seg_scan_display #(
    .N_DIGITS     (N),
    .SCAN_CNT_MAX (SCAN),
    .BLINK_CNT_MAX(10)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Reference: active-low segment codes for hex 0..f, dp bit set (off).
  logic [7:0] seg_tbl [16] = '{8'hc0, 8'hf9, 8'ha4, 8'hb0, 8'h99, 8'h92, 8'h82, 8'hf8,
                               8'h80, 8'h98, 8'h88, 8'h83, 8'hc6, 8'ha1, 8'h86, 8'h8e};

  int         passed = 0;
  int         total  = 0;
  bit         running = 0;
  int         run_cycles = 0;
  logic [31:0] m_data = '0;
  logic [7:0]  m_dp = '0;
  logic [7:0]  exp_en;
  logic [7:0]  exp_w;

  function automatic logic [7:0] pattern(input logic [31:0] d, input logic [7:0] dp,
                                         input logic lz, input int pos);
    logic [31:0] upper;
    upper = d >> (4 * pos);
    if (lz && pos > 0 && upper == 0) return 8'hff;
    return {~dp[pos], seg_tbl[upper[3:0]][6:0]};
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, expv, $time);
  endtask

  // One clock: predict from inputs as sampled at the edge, then compare just after it.
  task automatic cycle();
    int d;
    if (rst) begin
      running = 0; exp_en = 8'hff; exp_w = 8'hff;
    end else if (bus.locked) begin
      running = 0; exp_en = 8'hff; exp_w = 8'hff;
    end else if (running) begin
      d = (run_cycles / SCAN) % N;
      exp_en = ~(8'h01 << d);
      exp_w  = pattern(m_data, m_dp, bus.lz_blank, d);
      run_cycles++;
    end else begin
      exp_en = 8'hff; exp_w = 8'hff;
      if (bus.button) begin running = 1; run_cycles = 0; end
    end
    if (rst) begin
      m_data = '0; m_dp = '0;
    end else if (bus.load) begin
      m_data = bus.data; m_dp = bus.dp_mask;
    end
    @(posedge clk);
    #1;
    check("led_en", bus.led_en, exp_en);
    check("led_w", bus.led_w, exp_w);
  endtask

  task automatic do_load(input logic [31:0] d, input logic [7:0] dp);
    bus.data = d; bus.dp_mask = dp; bus.load = 1'b1;
    cycle();
    bus.load = 1'b0;
  endtask

  task automatic press();
    bus.button = 1'b1;
    cycle();
    bus.button = 1'b0;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    rst = 1'b1;
    bus.button = 1'b0; bus.locked = 1'b0; bus.load = 1'b0;
    bus.data = '0; bus.dp_mask = '0; bus.lz_blank = 1'b0;
`ifdef SEG_BLINK_EN
    bus.blink = 1'b0;
`endif
    #12;
    check("reset_en", bus.led_en, 8'hff);
    check("reset_w", bus.led_w, 8'hff);
    @(posedge clk); #1;
    rst = 1'b0;
    run(3);

    // Walking enables over a known word
    do_load(32'h1234_abcd, 8'h00);
    press();
    cycle();
    check("digit0_a1", bus.led_w, 8'ha1);
    run(SCAN * N + 3);

    // Leading-zero blanking on and off
    bus.lz_blank = 1'b1;
    do_load(32'h0000_0050, 8'h00);
    run(SCAN * N * 2);
    bus.lz_blank = 1'b0;
    run(SCAN * N);

    // Decimal point on digit 2
    do_load(32'h0000_0000, 8'h04);
    run(SCAN * N + 2);

    // Load on the last cycle of a digit, and load coinciding with stop
    run(SCAN - 1);
    do_load(32'h8765_4321, 8'h81);
    run(SCAN * 2);
    bus.locked = 1'b1; bus.button = 1'b1; bus.load = 1'b1; bus.data = 32'hfedc_ba98;
    cycle();
    bus.load = 1'b0;
    run(3);
    bus.locked = 1'b0; bus.button = 1'b0;
    run(4);
    press();
    run(SCAN * N);

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      bus.load = ($urandom_range(7) == 0);
      if (bus.load) begin
        bus.data    = $urandom >> (4 * $urandom_range(8));
        bus.dp_mask = 8'($urandom_range(255));
      end
      if ($urandom_range(40) == 0) bus.lz_blank = ~bus.lz_blank;
      bus.locked = ($urandom_range(60) == 0);
      bus.button = ($urandom_range(9) == 0);
      cycle();
    end
    bus.load = 1'b0; bus.locked = 1'b0; bus.button = 1'b0;

    // Asynchronous reset between edges while scanning
    press();
    run(SCAN * 3 + 2);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_en", bus.led_en, 8'hff);
    check("async_rst_w", bus.led_w, 8'hff);
    run(2);
    rst = 1'b0;
    run(SCAN * 2);
    do_load(32'h0000_0007, 8'h01);
    press();
    run(SCAN * N + 2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
